// File: rtl/p_mc_controller_if.sv
// Memory handshake and datapath control bundle between p_mc_controller (master)
// and the datapath/memory side (slave).
interface p_mc_controller_if;
  logic       mem_req;
  logic       mem_we;
  logic       mem_ack;
  logic       addr_sel;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic [1:0] alu_op;
  logic       reg_we;
  logic       wb_sel;
  logic [2:0] opcode;
  logic       zero;

  modport master (
    output mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op, reg_we, wb_sel,
    input  mem_ack, opcode, zero
  );

  modport slave (
    input  mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op, reg_we, wb_sel,
    output mem_ack, opcode, zero
  );
endinterface

// File: rtl/p_mc_controller.sv
// Multicycle control sequencer for the 8-bit processor datapath.
// Optional memory-access watchdog enabled by defining MEM_TIMEOUT_EN.
module p_mc_controller #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run_en,
  p_mc_controller_if.master     bus,
  output logic                  halted,
  output logic                  fault,
  output logic [3:0]            state,
  output logic [CNT_W-1:0]      retired
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC   = 4'd3,
    S_MEM    = 4'd4,
    S_WB     = 4'd5,
    S_BRANCH = 4'd6,
    S_HALT   = 4'd7,
    S_FAULT  = 4'd8
  } state_t;

  state_t     cur, nxt;
  logic       req, we, asel, irl, pci, pcl, rwe, wbs, hlt, flt;
  logic [1:0] aop;
  logic       retire;
  logic       tmo_expire;
  logic       is_ld, is_st;

  assign is_ld = (bus.opcode == 3'b100);
  assign is_st = (bus.opcode == 3'b101);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_IDLE;
    else        cur <= nxt;
  end

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_IDLE:   if (run_en) nxt = S_FETCH;
      S_FETCH:  if (run_en && bus.mem_ack) nxt = S_DECODE;
      S_DECODE: begin
        if (!bus.opcode[2])              nxt = S_EXEC;
        else if (!bus.opcode[1])         nxt = S_MEM;
        else if (!bus.opcode[0])         nxt = S_BRANCH;
        else                             nxt = S_HALT;
      end
      S_EXEC:   nxt = S_WB;
      S_WB:     nxt = S_FETCH;
      S_MEM:    if (bus.mem_ack) nxt = is_st ? S_FETCH : S_WB;
      S_BRANCH: nxt = S_FETCH;
      S_HALT:   nxt = S_HALT;
      S_FAULT:  nxt = S_FAULT;
      default:  nxt = S_IDLE;
    endcase
    if (tmo_expire) nxt = S_FAULT;
  end

  always_comb begin
    req  = 1'b0;
    we   = 1'b0;
    asel = 1'b0;
    irl  = 1'b0;
    pci  = 1'b0;
    pcl  = 1'b0;
    aop  = 2'b00;
    rwe  = 1'b0;
    wbs  = 1'b0;
    hlt  = 1'b0;
    flt  = 1'b0;
    unique case (cur)
      S_FETCH: if (run_en) begin
        req = 1'b1;
        if (bus.mem_ack) begin
          irl = 1'b1;
          pci = 1'b1;
        end
      end
      S_EXEC:   aop = bus.opcode[1:0];
      // LD opcode has [1:0]=00, so this also holds the address-add op through WB
      S_WB: begin
        rwe = 1'b1;
        aop = bus.opcode[1:0];
        wbs = is_ld;
      end
      S_MEM: begin
        req  = 1'b1;
        asel = 1'b1;
        we   = is_st;
      end
      S_BRANCH: begin
        aop = 2'b01;
        pcl = bus.zero;
      end
      S_HALT:  hlt = 1'b1;
      S_FAULT: flt = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_req  = req;
  assign bus.mem_we   = we;
  assign bus.addr_sel = asel;
  assign bus.ir_load  = irl;
  assign bus.pc_inc   = pci;
  assign bus.pc_load  = pcl;
  assign bus.alu_op   = aop;
  assign bus.reg_we   = rwe;
  assign bus.wb_sel   = wbs;
  assign halted       = hlt;
  assign fault        = flt;
  assign state        = cur;

  assign retire = (cur == S_WB) || (cur == S_BRANCH) ||
                  ((cur == S_MEM) && bus.mem_ack && is_st);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);

  logic [TMO_W-1:0] tmo_q;

  // An ack in the expiring cycle takes priority over the fault
  assign tmo_expire = req && !bus.mem_ack && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                            tmo_q <= '0;
    else if (bus.mem_ack || (cur != S_FETCH && cur != S_MEM)) tmo_q <= '0;
    else if (req)                                          tmo_q <= tmo_q + 1'b1;
  end
`else
  logic [31:0] tmo_unused;
  assign tmo_unused = MEM_TIMEOUT;
  assign tmo_expire = 1'b0;
`endif

endmodule

// File: tb/tb_p_mc_controller.sv
// Randomized instruction-level bench for p_mc_controller: each instruction is
// expanded into its expected per-cycle state/control trace and compared live.
module tb_p_mc_controller;
  localparam int unsigned CW = 4;

  localparam logic [3:0] ST_IDLE = 4'd0, ST_FETCH = 4'd1, ST_DEC = 4'd2, ST_EXEC = 4'd3,
                         ST_MEM = 4'd4, ST_WB = 4'd5, ST_BR = 4'd6, ST_HALT = 4'd7,
                         ST_FAULT = 4'd8;

  // {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op[1:0], reg_we, wb_sel, halted, fault}
  localparam logic [11:0] C_REQ = 12'h800, C_WE = 12'h400, C_ADDR = 12'h200, C_IR = 12'h100,
                          C_INC = 12'h080, C_PCL = 12'h040, C_RWE = 12'h008, C_WBS = 12'h004,
                          C_HLT = 12'h002, C_FLT = 12'h001;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          run_en = 1'b0;
  logic          halted, fault;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  p_mc_controller_if bus();

  p_mc_controller #(.CNT_W(CW), .MEM_TIMEOUT(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .run_en  (run_en),
    .bus     (bus.master),
    .halted  (halted),
    .fault   (fault),
    .state   (state),
    .retired (retired)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int unsigned model_ret = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ctrl_now();
    return {bus.mem_req, bus.mem_we, bus.addr_sel, bus.ir_load, bus.pc_inc, bus.pc_load,
            bus.alu_op, bus.reg_we, bus.wb_sel, halted, fault};
  endfunction

  function automatic logic [11:0] alu(input logic [1:0] op);
    return {6'b0, op, 4'b0};
  endfunction

  function automatic logic rb();
    return 1'($urandom());
  endfunction

  function automatic logic [2:0] rop();
    return 3'($urandom());
  endfunction

  task automatic cyc(input logic run, input logic ack, input logic z, input logic [2:0] op,
                     input logic [3:0] exp_st, input logic [11:0] exp_c, input string tag);
    @(negedge clk);
    run_en = run;
    bus.mem_ack = ack;
    bus.zero = z;
    bus.opcode = op;
    #1;
    check({tag, ".state"}, 32'(state), 32'(exp_st));
    check({tag, ".ctrl"}, 32'(ctrl_now()), 32'(exp_c));
    check({tag, ".retired"}, 32'(retired), 32'(model_ret % (1 << CW)));
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      reset = 1'b0;
      run_en = rb();
      bus.mem_ack = rb();
      model_ret = 0;
      #1;
      check("rst.state", 32'(state), 32'(ST_IDLE));
      check("rst.ctrl", 32'(ctrl_now()), 32'h0);
      check("rst.retired", 32'(retired), 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    run_en = 1'b0;
    cyc(1'b0, rb(), rb(), rop(), ST_IDLE, 12'h0, "idle_hold");
    cyc(1'b1, rb(), rb(), rop(), ST_IDLE, 12'h0, "idle_go");
  endtask

  task automatic fetch(input int pauses, input int waits);
    for (int i = 0; i < pauses; i++) cyc(1'b0, rb(), rb(), rop(), ST_FETCH, 12'h0, "pause");
    for (int i = 0; i < waits; i++)  cyc(1'b1, 1'b0, rb(), rop(), ST_FETCH, C_REQ, "fwait");
    cyc(1'b1, 1'b1, rb(), rop(), ST_FETCH, C_REQ | C_IR | C_INC, "fack");
  endtask

  task automatic instr(input logic [2:0] op, input int pauses, input int fwaits,
                       input int mwaits, input logic z);
    fetch(pauses, fwaits);
    cyc(rb(), rb(), rb(), op, ST_DEC, 12'h0, "decode");
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        cyc(rb(), rb(), rb(), op, ST_EXEC, alu(op[1:0]), "exec");
        cyc(rb(), rb(), rb(), op, ST_WB, C_RWE | alu(op[1:0]), "wb");
        model_ret++;
      end
      3'd4: begin
        for (int i = 0; i < mwaits; i++)
          cyc(rb(), 1'b0, rb(), op, ST_MEM, C_REQ | C_ADDR, "ld_wait");
        cyc(rb(), 1'b1, rb(), op, ST_MEM, C_REQ | C_ADDR, "ld_ack");
        cyc(rb(), rb(), rb(), op, ST_WB, C_RWE | C_WBS, "ld_wb");
        model_ret++;
      end
      3'd5: begin
        for (int i = 0; i < mwaits; i++)
          cyc(rb(), 1'b0, rb(), op, ST_MEM, C_REQ | C_ADDR | C_WE, "st_wait");
        cyc(rb(), 1'b1, rb(), op, ST_MEM, C_REQ | C_ADDR | C_WE, "st_ack");
        model_ret++;
      end
      3'd6: begin
        cyc(rb(), rb(), z, op, ST_BR, alu(2'b01) | (z ? C_PCL : 12'h0), "beq");
        model_ret++;
      end
      default: begin
        for (int i = 0; i < 20; i++)
          cyc(rb(), rb(), rb(), rop(), ST_HALT, C_HLT, "halt");
      end
    endcase
  endtask

  initial begin
    bus.mem_ack = 1'b0;
    bus.zero = 1'b0;
    bus.opcode = 3'd0;

    do_reset();

    // Directed: ADD with zero wait states, LD/ST with 2-cycle MEM wait, BEQ taken and not
    instr(3'd0, 0, 0, 0, 1'b0);
    instr(3'd4, 0, 0, 2, 1'b0);
    instr(3'd5, 0, 0, 2, 1'b0);
    instr(3'd6, 0, 0, 0, 1'b1);
    instr(3'd6, 0, 0, 0, 1'b0);

    // Random program long enough to wrap the 4-bit retired counter
    for (int n = 0; n < 40; n++)
      instr(3'($urandom_range(0, 6)), $urandom_range(0, 2), $urandom_range(0, 3),
            $urandom_range(0, 3), rb());

    instr(3'd7, 1, 1, 0, 1'b0);

    // Asynchronous reset in the middle of a held LD access
    do_reset();
    instr(3'd1, 0, 0, 0, 1'b0);
    fetch(0, 0);
    cyc(1'b1, 1'b0, 1'b0, 3'd4, ST_DEC, 12'h0, "decode_ld");
    cyc(1'b1, 1'b0, 1'b0, 3'd4, ST_MEM, C_REQ | C_ADDR, "mem_before_rst");
    #2 reset = 1'b0;
    model_ret = 0;
    #1;
    check("async_rst.state", 32'(state), 32'(ST_IDLE));
    check("async_rst.ctrl", 32'(ctrl_now()), 32'h0);
    check("async_rst.retired", 32'(retired), 32'h0);

`ifdef MEM_TIMEOUT_EN
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, rb(), rop(), ST_FETCH, C_REQ, "tmo_wait");
    for (int i = 0; i < 6; i++) cyc(rb(), rb(), rb(), rop(), ST_FAULT, C_FLT, "tmo_fault");
    do_reset();
    fetch(0, 3);
    cyc(1'b1, 1'b0, 1'b0, 3'd0, ST_DEC, 12'h0, "tmo_late_ack");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/p_mc_controller.md
Name: p_mc_controller

Overview:
- Multicycle control sequencer for the 8-bit processor datapath.
- Fetches each instruction over a single shared memory port using a req/ack handshake, decodes the 3-bit opcode, and drives per-state datapath controls (PC, IR, ALU, register file, write-back mux).
- Sits between the top-level processor shell and the datapath; the datapath holds the PC, IR, register file and ALU.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, cycles `mem_req` may stay high without `mem_ack` before a fault; used only with `MEM_TIMEOUT_EN`.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- run_en  input  1  allows leaving IDLE and starting each new fetch.
- opcode  input  3  IR[7:5] from the datapath; valid from DECODE onward.
- zero  input  1  ALU zero flag, combinational, same cycle.
- mem_ack  input  1  memory completes the current access this cycle.
- mem_req  output  1  memory access request.
- mem_we  output  1  write strobe, qualified by `mem_req`.
- addr_sel  output  1  memory address select: 0 = PC, 1 = ALU result.
- ir_load  output  1  load IR from memory read data.
- pc_inc  output  1  PC <= PC + 1.
- pc_load  output  1  PC <= branch target.
- alu_op  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- reg_we  output  1  register file write enable.
- wb_sel  output  1  write-back source: 0 = ALU, 1 = memory.
- halted  output  1  high in HALT.
- fault  output  1  high in FAULT.
- state  output  4  current state code, for debug.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- State codes: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, BRANCH=6, HALT=7, FAULT=8.
- State and counters are registered. Outputs are decoded combinationally from state, plus `mem_ack`/`zero`/opcode where stated. Any output not listed for a state is 0.
- Reset (asynchronous, reset=0):
  - state=IDLE, retired=0, timeout counter=0.
  - All outputs 0 while reset is low.
  - Reset mid-access abandons the access immediately.
- IDLE: go to FETCH when run_en=1.
- FETCH:
  - run_en=0: stay in FETCH with `mem_req`=0 (clean pause).
  - Otherwise `mem_req`=1, `addr_sel`=0.
  - On `mem_ack`, in the same cycle: `ir_load`=1, `pc_inc`=1, next state DECODE.
  - Without `mem_ack`: stay in FETCH holding the request.
- DECODE: one cycle, no outputs. Next state by opcode:
  - 000–011 (ADD/SUB/AND/OR) -> EXEC
  - 100 (LD) or 101 (ST) -> MEM
  - 110 (BEQ) -> BRANCH
  - 111 -> HALT
- EXEC: `alu_op`=opcode[1:0]; next state WB.
- WB: `reg_we`=1, `alu_op` held. `wb_sel`=1 if the opcode is LD, else 0. Next state FETCH; retired +1.
- MEM (`alu_op`=00 for address computation, `addr_sel`=1, `mem_req`=1):
  - ST: `mem_we`=1. On `mem_ack` -> FETCH, retired +1.
  - LD: `mem_we`=0. On `mem_ack` -> WB; LD retires in WB.
- BRANCH: `alu_op`=01. If `zero`=1, `pc_load`=1. Next state FETCH; retired +1.
- HALT: sticky until reset; `halted`=1; not counted as retired.
- Latencies with zero memory wait states:
  - ALU op: 4 cycles
  - ST: 3 cycles
  - LD: 4 cycles
  - BEQ: 3 cycles
  - Each cycle without `mem_ack` adds 1 cycle.
- `retired` wraps from 2^CNT_W−1 to 0.
- `mem_ack` outside FETCH/MEM is ignored.
- Only one of `pc_inc`/`pc_load` is ever high in a cycle.

Optional Feature:
- Macro: `MEM_TIMEOUT_EN`.
- Defined:
  - A counter increments every cycle that `mem_req`=1 and `mem_ack`=0. It clears on `mem_ack` and on leaving FETCH/MEM.
  - When the counter reaches MEM_TIMEOUT, the next state is FAULT.
  - FAULT: `fault`=1, all other controls 0, sticky until reset.
  - `mem_ack` arriving in the same cycle the count would expire wins (normal progress).
- Undefined: no counter; accesses wait indefinitely; `fault` tied to 0; state 8 unreachable.

Test Plan:
- Reset and start: reset=0 for 2 cycles, then 1 with run_en=0 -> state=0, all outputs 0, retired=0. Raise run_en -> state=1 and `mem_req`=1 next cycle.
- ADD with `mem_ack` always 1: opcode 000 -> states 1,2,3,5,1. `ir_load`/`pc_inc` pulse in FETCH, `alu_op`=00 in EXEC, `reg_we`=1 in WB, retired=1.
- LD then ST, `mem_ack` delayed 2 cycles in MEM:
  - LD: MEM lasts 3 cycles with `addr_sel`=1 and `mem_we`=0, then WB with `wb_sel`=1.
  - ST: `mem_we`=1 for 3 cycles, then FETCH.
  - retired=2.
- BEQ: zero=1 -> `pc_load`=1 for 1 cycle in state 6. Repeat with zero=0 -> `pc_load`=0. retired +1 each.
- HALT and pause:
  - opcode 111 -> state 7, `halted`=1, held for 20 cycles regardless of inputs.
  - run_en=0 during FETCH -> `mem_req`=0 until run_en returns.
  - Async reset mid-MEM -> state=0 within the same cycle.
- With `MEM_TIMEOUT_EN`, MEM_TIMEOUT=4, `mem_ack` stuck at 0 in FETCH -> after 4 requesting cycles state=8 and `fault`=1, held until reset. Ack on the 4th cycle -> no fault.
